// File: rtl/rx_capture_ctrl.sv
// Circular-buffer capture controller in front of the RX sample BRAM: records a pre/post-trigger
// window through port A, then replays it in order through port B as a framed sample stream.
module rx_capture_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int PRE_TRIG  = 64,
  parameter int POST_TRIG = 128
) (
  input  logic              clk,
  input  logic              rrx_rst,
  input  logic [DATA_W-1:0] smp_in,
  input  logic              smp_valid,
  input  logic              trig,
  output logic              armed,
  output logic              busy,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dia,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_dob,
  output logic [DATA_W-1:0] win_data,
  output logic              win_valid,
  output logic              win_first,
  output logic              win_last,
  output logic              drop
);

  localparam int WIN = PRE_TRIG + POST_TRIG;
  localparam int CW  = ADDR_W + 1;

  typedef enum logic [1:0] {S_FILL, S_ARMED, S_POST, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic [CW-1:0]     rd_k_q, rd_k_d;
  logic              armed_q, armed_d;
  logic              busy_q, busy_d;
  logic              win_valid_q, win_valid_d;
  logic              win_first_q, win_first_d;
  logic              win_last_q, win_last_d;
  logic              wr_en;
  logic              rd_en;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    fill_cnt_d = fill_cnt_q;
    post_cnt_d = post_cnt_q;
    rd_k_d     = rd_k_q;

    wr_en = smp_valid && (state_q != S_DRAIN);
    rd_en = (state_q == S_DRAIN) && (rd_k_q < CW'(WIN));

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;

    case (state_q)
      S_FILL: begin
        if (smp_valid) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_d == CW'(PRE_TRIG)) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (trig) begin
          // The write landing in the trigger cycle is the first post-trigger sample.
          trig_ptr_d = wr_ptr_q;
          post_cnt_d = smp_valid ? CW'(1) : '0;
          rd_k_d     = '0;
          state_d    = (post_cnt_d == CW'(POST_TRIG)) ? S_DRAIN : S_POST;
        end
      end
      S_POST: begin
        if (smp_valid) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == CW'(POST_TRIG)) begin
            rd_k_d  = '0;
            state_d = S_DRAIN;
          end
        end
      end
      default: begin
        // One extra cycle after the last read lets the final sample leave before refilling.
        if (rd_k_q == CW'(WIN)) begin
          fill_cnt_d = '0;
          state_d    = S_FILL;
        end else begin
          rd_k_d = rd_k_q + 1'b1;
        end
      end
    endcase

    armed_d     = (state_d == S_ARMED);
    busy_d      = (state_d == S_POST) || (state_d == S_DRAIN);
    win_valid_d = rd_en;
    win_first_d = rd_en && (rd_k_q == '0);
    win_last_d  = rd_en && (rd_k_q == CW'(WIN - 1));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rrx_rst) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rd_k_q      <= '0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_first_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_k_q      <= rd_k_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      win_valid_q <= win_valid_d;
      win_first_q <= win_first_d;
      win_last_q  <= win_last_d;
    end
  end

  assign bram_ena   = wr_en;
  assign bram_wea   = wr_en;
  assign bram_addra = (state_q == S_DRAIN) ? '0 : wr_ptr_q;
  assign bram_dia   = (state_q == S_DRAIN) ? '0 : smp_in;
  assign drop       = smp_valid && (state_q == S_DRAIN);

  // Window start is trig_ptr - PRE_TRIG; the subtraction wraps naturally at ADDR_W bits.
  assign bram_enb   = rd_en;
  assign bram_addrb = rd_en ? (trig_ptr_q - ADDR_W'(PRE_TRIG) + rd_k_q[ADDR_W-1:0]) : '0;

  // The BRAM output register supplies the one-cycle read latency.
  assign win_data  = win_valid_q ? bram_dob : '0;
  assign win_valid = win_valid_q;
  assign win_first = win_first_q;
  assign win_last  = win_last_q;
  assign armed     = armed_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rx_capture_ctrl.sv
// Bench for rx_capture_ctrl: a BRAM model on the ports plus a counting reference model of the
// capture window, driven with ramps and $urandom gaps, data and trigger timing.
module tb_rx_capture_ctrl;

  localparam int PRE  = 64;
  localparam int POST = 128;
  localparam int W    = PRE + POST;

  logic        clk = 1'b0;
  logic        rrx_rst = 1'b0;
  logic [15:0] smp_in = '0;
  logic        smp_valid = 1'b0;
  logic        trig = 1'b0;
  logic        armed, busy, bram_ena, bram_wea, bram_enb;
  logic [7:0]  bram_addra, bram_addrb;
  logic [15:0] bram_dia, bram_dob, win_data;
  logic        win_valid, win_first, win_last, drop;

  logic [15:0] mem  [256];
  logic [15:0] snap [256];

  int n_vec  = 0;
  int n_fail = 0;
  int ramp   = 0;

  // Reference model: write count, history depth, capture progress and a shadow of the buffer.
  int          m_wptr, m_hist, m_post, m_tptr, m_dk;
  bit          m_cap, m_drain;
  logic [15:0] rmem [256];

  always #5 clk = ~clk;

  rx_capture_ctrl dut (
    .clk(clk), .rrx_rst(rrx_rst), .smp_in(smp_in), .smp_valid(smp_valid), .trig(trig),
    .armed(armed), .busy(busy), .bram_ena(bram_ena), .bram_wea(bram_wea),
    .bram_addra(bram_addra), .bram_dia(bram_dia), .bram_enb(bram_enb),
    .bram_addrb(bram_addrb), .bram_dob(bram_dob), .win_data(win_data),
    .win_valid(win_valid), .win_first(win_first), .win_last(win_last), .drop(drop)
  );

  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dia;
    if (bram_enb) bram_dob <= mem[bram_addrb];
  end

  task automatic model_reset();
    m_wptr = 0; m_hist = 0; m_post = 0; m_tptr = 0; m_dk = 0; m_cap = 0; m_drain = 0;
  endtask

  // Drive one cycle, capture the DUT outputs and the model's expectation, then advance the model.
  task automatic cycle(input logic v, input logic [15:0] d, input logic t, input logic rst,
                       output logic [56:0] act, output logic [56:0] want);
    logic       e_armed, e_busy, e_ena, e_enb, e_wv, e_first, e_last, e_drop;
    logic [7:0] e_addra, e_addrb;
    logic [15:0] e_dia, e_data;
    e_armed = 0; e_busy = 0; e_ena = 0; e_enb = 0; e_wv = 0; e_first = 0; e_last = 0;
    e_drop = 0; e_addra = 0; e_addrb = 0; e_dia = 0; e_data = 0;
    @(negedge clk);
    smp_valid = v; smp_in = d; trig = t; rrx_rst = rst;
    #1;
    act = {armed, busy, bram_ena, bram_wea, bram_addra, bram_dia, bram_enb, bram_addrb,
           win_valid, win_first, win_last, win_data, drop};
    if (!m_drain) begin
      e_armed = !m_cap && (m_hist >= PRE);
      e_busy  = m_cap;
      e_ena   = v;
      e_addra = 8'(m_wptr);
      e_dia   = d;
    end else begin
      e_busy = 1; e_drop = v;
      if (m_dk < W) begin
        e_enb   = 1;
        e_addrb = 8'((m_tptr - PRE + m_dk) & 255);
      end
      if (m_dk >= 1) begin
        e_wv    = 1;
        e_data  = rmem[(m_tptr - PRE + m_dk - 1) & 255];
        e_first = (m_dk == 1);
        e_last  = (m_dk == W);
      end
    end
    want = {e_armed, e_busy, e_ena, e_ena, e_addra, e_dia, e_enb, e_addrb,
            e_wv, e_first, e_last, e_data, e_drop};
    if (!rst) begin
      model_reset();
    end else if (!m_drain) begin
      if (!m_cap) begin
        if (m_hist >= PRE && t) begin
          m_cap = 1; m_tptr = m_wptr; m_post = v ? 1 : 0;
        end else if (v && m_hist < PRE) begin
          m_hist++;
        end
      end else if (v) begin
        m_post++;
      end
      if (v) begin
        rmem[m_wptr] = d;
        m_wptr = (m_wptr + 1) % 256;
      end
      if (m_cap && m_post == POST) begin
        m_drain = 1; m_dk = 0;
      end
    end else if (m_dk == W) begin
      m_drain = 0; m_cap = 0; m_hist = 0;
    end else begin
      m_dk++;
    end
  endtask

  function automatic bit model_armed();
    return !m_cap && !m_drain && (m_hist >= PRE);
  endfunction

  task automatic test_reset();
    logic [56:0] act, want;
    rrx_rst = 0; smp_valid = 0; trig = 0; smp_in = 0;
    repeat (3) @(posedge clk);
    model_reset();
    ramp = 0;
    cycle(0, 16'h0, 0, 1, act, want);
    n_vec++;
    if (act !== 57'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", act, 57'd0);
    end
  endtask

  task automatic test_fill();
    logic [56:0] act, want;
    for (int c = 0; c < PRE; c++) begin
      cycle(1, 16'(ramp), 0, 1, act, want);
      ramp++;
      n_vec++;
      if (act !== want) begin
        n_fail++; $display("FAIL fill_vec c=%0d got=%h want=%h", c, act, want);
      end
      n_vec++;
      if ({armed, bram_addra, bram_dia} !== {1'b0, 8'(c), 16'(c)}) begin
        n_fail++;
        $display("FAIL fill_addr c=%0d got armed=%b addra=%0d dia=%0d want 0/%0d/%0d",
                 c, armed, bram_addra, bram_dia, c, c);
      end
    end
    cycle(0, 16'h0, 0, 1, act, want);
    n_vec++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL fill_armed got=%b want=1", armed);
    end
  endtask

  task automatic test_window();
    logic [56:0] act, want;
    logic v, t;
    int n_win = 0;
    for (int c = 0; c < 1000 && n_win < W; c++) begin
      v = !m_drain;
      t = model_armed() && (m_wptr == 100);
      cycle(v, 16'(ramp), t, 1, act, want);
      if (v) ramp++;
      n_vec++;
      if (act !== want) begin
        n_fail++; $display("FAIL window_vec c=%0d got=%h want=%h", c, act, want);
      end
      if (win_valid === 1'b1) begin
        n_vec++;
        if ({win_data, win_first, win_last} !== {16'(36 + n_win), n_win == 0, n_win == W - 1}) begin
          n_fail++;
          $display("FAIL window_data k=%0d got=%0d f=%b l=%b want=%0d", n_win, win_data,
                   win_first, win_last, 36 + n_win);
        end
        n_win++;
      end
    end
    n_vec++;
    if (n_win != W) begin
      n_fail++; $display("FAIL window_count got=%0d want=%0d", n_win, W);
    end
  endtask

  task automatic test_wrap();
    logic [56:0] act, want;
    logic v, t;
    logic [15:0] prev = '0;
    int n_win = 0, n_rd = 0;
    for (int c = 0; c < 3000 && n_win < W; c++) begin
      v = !m_drain && ($urandom_range(0, 3) != 0);
      t = model_armed() && (m_wptr == 20);
      cycle(v, 16'(ramp), t, 1, act, want);
      if (v) ramp++;
      n_vec++;
      if (act !== want) begin
        n_fail++; $display("FAIL wrap_vec c=%0d got=%h want=%h", c, act, want);
      end
      if (bram_enb === 1'b1) begin
        if (n_rd == 0 || n_rd == W - 1) begin
          n_vec++;
          if (bram_addrb !== ((n_rd == 0) ? 8'd212 : 8'd147)) begin
            n_fail++; $display("FAIL wrap_addrb k=%0d got=%0d", n_rd, bram_addrb);
          end
        end
        n_rd++;
      end
      if (win_valid === 1'b1) begin
        if (n_win > 0) begin
          n_vec++;
          if (win_data !== prev + 16'd1) begin
            n_fail++; $display("FAIL wrap_contig k=%0d got=%0d want=%0d", n_win, win_data, prev + 16'd1);
          end
        end
        prev = win_data;
        n_win++;
      end
    end
    n_vec++;
    if (n_win != W || n_rd != W) begin
      n_fail++; $display("FAIL wrap_count got win=%0d rd=%0d want=%0d", n_win, n_rd, W);
    end
  endtask

  task automatic test_ignored_trig();
    logic [56:0] act, want;
    logic v, t;
    int n_win = 0, wait_armed = $urandom_range(5, 30), exp_start = -1;
    bit seen_rd = 0;
    for (int c = 0; c < 3000 && n_win < W; c++) begin
      v = ($urandom_range(0, 3) != 0);
      t = 0;
      if (!m_cap && !m_drain && m_hist == 10) t = 1;
      if (model_armed()) begin
        if (wait_armed == 0) begin
          t = 1; exp_start = (m_wptr - PRE) & 255;
        end else begin
          wait_armed--;
        end
      end
      if (m_cap && !m_drain && m_post == 50) t = 1;
      cycle(v, 16'($urandom), t, 1, act, want);
      n_vec++;
      if (act !== want) begin
        n_fail++; $display("FAIL ignore_vec c=%0d got=%h want=%h", c, act, want);
      end
      if (bram_enb === 1'b1 && !seen_rd) begin
        seen_rd = 1;
        n_vec++;
        if (int'(bram_addrb) != exp_start) begin
          n_fail++; $display("FAIL ignore_start got=%0d want=%0d", bram_addrb, exp_start);
        end
      end
      if (win_valid === 1'b1) n_win++;
    end
    n_vec++;
    if (n_win != W) begin
      n_fail++; $display("FAIL ignore_count got=%0d want=%0d", n_win, W);
    end
  endtask

  task automatic test_drain_drop();
    logic [56:0] act, want;
    logic t;
    bit first_drain;
    int n_win = 0, n_drop = 0, bad = 0;
    for (int c = 0; c < 3000 && n_win < W; c++) begin
      t = model_armed() && ($urandom_range(0, 7) == 0);
      first_drain = m_drain && (m_dk == 0);
      cycle(1, 16'($urandom), t, 1, act, want);
      if (first_drain) for (int i = 0; i < 256; i++) snap[i] = mem[i];
      n_vec++;
      if (act !== want) begin
        n_fail++; $display("FAIL drop_vec c=%0d got=%h want=%h", c, act, want);
      end
      if (drop === 1'b1) n_drop++;
      if (win_valid === 1'b1) n_win++;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_fail++; $display("FAIL drop_mem_changed got=%0d changed words want=0", bad);
    end
    n_vec++;
    if (n_drop != W + 1) begin
      n_fail++; $display("FAIL drop_count got=%0d want=%0d", n_drop, W + 1);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [56:0] act, want;
    logic v, t, rst;
    bit hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      v = !m_drain;
      t = model_armed() && ($urandom_range(0, 3) == 0);
      rst = !(m_drain && m_dk == 50);
      hit = !rst;
      cycle(v, 16'(ramp), t, rst, act, want);
      if (v) ramp++;
      n_vec++;
      if (act !== want) begin
        n_fail++; $display("FAIL rstdrain_vec c=%0d got=%h want=%h", c, act, want);
      end
    end
    n_vec++;
    if (!hit) begin
      n_fail++; $display("FAIL rstdrain_timeout got=no drain want=drain k=50");
    end
    cycle(0, 16'h0, 0, 1, act, want);
    n_vec++;
    if (act !== 57'd0) begin
      n_fail++; $display("FAIL rstdrain_zero got=%h want=%h", act, 57'd0);
    end
    cycle(1, 16'hABCD, 0, 1, act, want);
    n_vec++;
    if ({bram_ena, bram_addra, bram_dia, busy} !== {1'b1, 8'd0, 16'hABCD, 1'b0}) begin
      n_fail++;
      $display("FAIL rstdrain_restart got ena=%b addra=%0d dia=%h busy=%b want 1/0/abcd/0",
               bram_ena, bram_addra, bram_dia, busy);
    end
    for (int c = 0; c < 20; c++) begin
      cycle($urandom_range(0, 1) == 1, 16'($urandom), 0, 1, act, want);
      n_vec++;
      if (act !== want) begin
        n_fail++; $display("FAIL rstdrain_refill c=%0d got=%h want=%h", c, act, want);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0; rmem[i] = '0;
    end
    model_reset();
    test_reset();
    test_fill();
    test_window();
    test_wrap();
    test_ignored_trig();
    test_drain_drop();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
